// File: rtl/rc4_plaintext_checker.sv
// ============================================================================
// rc4_plaintext_checker
//   Checks one RC4 core's decrypted byte stream against the lowercase/space
//   alphabet, issues a per-key verdict and latches the first passing key.
//   Optional capture buffer: define RC4_PLAINTEXT_CAPTURE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_plaintext_checker #(
  parameter int         MSG_LEN = 32,
  parameter int         KEY_W   = 24,
  parameter logic [7:0] CHAR_LO = 8'h61,
  parameter logic [7:0] CHAR_HI = 8'h7A,
  parameter logic [7:0] CHAR_SP = 8'h20,
  localparam int        IDX_W   = $clog2(MSG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_key_in,
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_data,
  input  logic [IDX_W-1:0] i_in_addr,
  output logic             o_early_reject,
  output logic             o_verdict_valid,
  output logic             o_verdict_pass,
  output logic             o_found,
  output logic [KEY_W-1:0] o_found_key,
  output logic [KEY_W-1:0] o_keys_checked,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [7:0]       o_rd_data
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2,
    S_FOUND  = 2'd3
  } state_t;

  state_t           r_state;
  logic [KEY_W-1:0] r_cur_key;
  logic [KEY_W-1:0] r_found_key;
  logic [KEY_W-1:0] r_keys_checked;
  logic [IDX_W-1:0] r_idx;
  logic             r_pass;
  logic             r_verdict_valid;
  logic             r_early_reject;
  logic             r_found;

  logic w_char_ok;
  logic w_legal;
  logic w_take;

  assign w_char_ok = ((i_in_data >= CHAR_LO) && (i_in_data <= CHAR_HI)) ||
                     (i_in_data == CHAR_SP);
  assign w_legal   = w_char_ok && (i_in_addr == r_idx);
  // abort and restart both pre-empt a byte offered in the same cycle
  assign w_take    = (r_state == S_CHECK) && i_in_valid && !i_abort && !i_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cur_key       <= '0;
      r_found_key     <= '0;
      r_keys_checked  <= '0;
      r_idx           <= '0;
      r_pass          <= 1'b0;
      r_verdict_valid <= 1'b0;
      r_early_reject  <= 1'b0;
      r_found         <= 1'b0;
    end else begin
      r_verdict_valid <= 1'b0;
      r_early_reject  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_cur_key <= i_key_in;
            r_idx     <= '0;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (i_start) begin
            r_cur_key <= i_key_in;
            r_idx     <= '0;
          end else if (w_take) begin
            if (!w_legal) begin
              r_pass          <= 1'b0;
              r_verdict_valid <= 1'b1;
              r_early_reject  <= 1'b1;
              r_state         <= S_REPORT;
            end else if (r_idx == c_LAST_IDX) begin
              r_pass          <= 1'b1;
              r_verdict_valid <= 1'b1;
              r_state         <= S_REPORT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (r_keys_checked != '1) r_keys_checked <= r_keys_checked + 1'b1;
          if (r_pass) begin
            r_found_key <= r_cur_key;
            r_found     <= 1'b1;
            r_state     <= S_FOUND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FOUND: r_state <= S_FOUND;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready      = (r_state == S_CHECK);
  assign o_early_reject  = r_early_reject;
  assign o_verdict_valid = r_verdict_valid;
  assign o_verdict_pass  = r_pass && r_verdict_valid;
  assign o_found         = r_found;
  assign o_found_key     = r_found_key;
  assign o_keys_checked  = r_keys_checked;

`ifdef RC4_PLAINTEXT_CAPTURE_EN
  logic [7:0] r_buf [MSG_LEN];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      // legal implies i_in_addr == r_idx, so r_idx is always in range
      if (w_take && w_legal && !r_found) r_buf[r_idx] <= i_in_data;
      r_rd_data <= r_buf[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
`else
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^i_rd_addr;
  assign o_rd_data        = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rc4_plaintext_checker.sv
// Self-checking bench for rc4_plaintext_checker with a behavioural model of
// the alphabet rule and verdict/count bookkeeping.
`default_nettype none

module tb_rc4_plaintext_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] key_in = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [4:0]  in_addr = '0;
  logic        early_reject;
  logic        verdict_valid;
  logic        verdict_pass;
  logic        found;
  logic [23:0] found_key;
  logic [23:0] keys_checked;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [23:0] exp_kc = '0;

  rc4_plaintext_checker dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_key_in       (key_in),
    .i_abort        (abort),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .i_in_addr      (in_addr),
    .o_early_reject (early_reject),
    .o_verdict_valid(verdict_valid),
    .o_verdict_pass (verdict_pass),
    .o_found        (found),
    .o_found_key    (found_key),
    .o_keys_checked (keys_checked),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] v;
    do v = 8'($urandom); while (is_legal(v));
    return v;
  endfunction

  task automatic pulse_start(input logic [23:0] k);
    start = 1'b1; key_in = k; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] a);
    in_valid = 1'b1; in_data = d; in_addr = a; tick(); in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_kc = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else n_pass++;
    n_chk++; if (verdict_valid !== 1'b0) $display("FAIL reset_vv got=%0b exp=0", verdict_valid); else n_pass++;
    n_chk++; if (found !== 1'b0 || found_key !== 24'h0) $display("FAIL reset_found got=%0b/%h exp=0/0", found, found_key); else n_pass++;
    n_chk++; if (keys_checked !== 24'h0) $display("FAIL reset_kc got=%h exp=0", keys_checked); else n_pass++;
    n_chk++; if (rd_data !== 8'h00 || early_reject !== 1'b0) $display("FAIL reset_misc got=%h/%0b exp=00/0", rd_data, early_reject); else n_pass++;
  endtask

  task automatic test_early_fail();
    pulse_start(24'h000010);
    n_chk++; if (in_ready !== 1'b1) $display("FAIL ef_in_ready got=%0b exp=1", in_ready); else n_pass++;
    send(8'h61, 5'd0);
    send(8'h62, 5'd1);
    n_chk++; if (verdict_valid !== 1'b0) $display("FAIL ef_early_vv got=%0b exp=0", verdict_valid); else n_pass++;
    send(8'h7B, 5'd2);
    n_chk++; if (verdict_valid !== 1'b1 || verdict_pass !== 1'b0) $display("FAIL ef_verdict got=%0b/%0b exp=1/0", verdict_valid, verdict_pass); else n_pass++;
    n_chk++; if (early_reject !== 1'b1) $display("FAIL ef_early_reject got=%0b exp=1", early_reject); else n_pass++;
    exp_kc++;
    tick();
    n_chk++; if (early_reject !== 1'b0 || verdict_valid !== 1'b0) $display("FAIL ef_pulse_width got=%0b/%0b exp=0/0", early_reject, verdict_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b0 || found !== 1'b0) $display("FAIL ef_idle got=%0b/%0b exp=0/0", in_ready, found); else n_pass++;
    n_chk++; if (keys_checked !== exp_kc) $display("FAIL ef_kc got=%h exp=%h", keys_checked, exp_kc); else n_pass++;
  endtask

  task automatic test_index_mismatch();
    pulse_start(24'h000011);
    send(8'h61, 5'd3);
    n_chk++; if (verdict_valid !== 1'b1 || verdict_pass !== 1'b0) $display("FAIL im_verdict got=%0b/%0b exp=1/0", verdict_valid, verdict_pass); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL im_in_ready got=%0b exp=0", in_ready); else n_pass++;
    exp_kc++;
    tick();
    n_chk++; if (keys_checked !== exp_kc) $display("FAIL im_kc got=%h exp=%h", keys_checked, exp_kc); else n_pass++;
  endtask

  task automatic test_abort_restart();
    int seen;
    pulse_start(24'h000030);
    for (int i = 0; i < 10; i++) send(rand_legal(), 5'(i));
    abort = 1'b1; tick(); abort = 1'b0;
    seen = verdict_valid;
    tick();
    n_chk++; if (seen != 0 || verdict_valid !== 1'b0) $display("FAIL ab_no_verdict got=%0d/%0b exp=0/0", seen, verdict_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b0 || keys_checked !== exp_kc) $display("FAIL ab_idle got=%0b/%h exp=0/%h", in_ready, keys_checked, exp_kc); else n_pass++;
    // restart mid-check, then illegal 4th byte: verdict must come at addr 3
    pulse_start(24'h000040);
    for (int i = 0; i < 5; i++) send(rand_legal(), 5'(i));
    pulse_start(24'h000020);
    n_chk++; if (in_ready !== 1'b1 || verdict_valid !== 1'b0) $display("FAIL rs_check got=%0b/%0b exp=1/0", in_ready, verdict_valid); else n_pass++;
    for (int i = 0; i < 3; i++) send(rand_legal(), 5'(i));
    n_chk++; if (verdict_valid !== 1'b0) $display("FAIL rs_idx_reset got=%0b exp=0", verdict_valid); else n_pass++;
    send(8'h41, 5'd3);
    n_chk++; if (verdict_valid !== 1'b1 || verdict_pass !== 1'b0) $display("FAIL rs_verdict got=%0b/%0b exp=1/0", verdict_valid, verdict_pass); else n_pass++;
    exp_kc++;
    tick();
    // start+abort together from CHECK and from IDLE
    pulse_start(24'h000050);
    send(8'h61, 5'd0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_chk++; if (in_ready !== 1'b0 || verdict_valid !== 1'b0) $display("FAIL sa_check got=%0b/%0b exp=0/0", in_ready, verdict_valid); else n_pass++;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL sa_idle got=%0b exp=0", in_ready); else n_pass++;
    n_chk++; if (keys_checked !== exp_kc) $display("FAIL sa_kc got=%h exp=%h", keys_checked, exp_kc); else n_pass++;
  endtask

  task automatic test_random_fail();
    for (int c = 0; c < 16; c++) begin
      logic [7:0] d [32];
      logic [4:0] a [32];
      int p;
      int first_bad;
      p = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++) begin d[i] = rand_legal(); a[i] = 5'(i); end
      if ($urandom_range(0, 1) == 1) d[p] = rand_illegal();
      else a[p] = 5'(p + $urandom_range(1, 31));
      first_bad = -1;
      for (int i = 0; i < 32; i++)
        if (first_bad < 0 && !(is_legal(d[i]) && a[i] == 5'(i))) first_bad = i;
      pulse_start(24'($urandom));
      for (int i = 0; i <= first_bad; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(d[i], a[i]);
        n_chk++; if (verdict_valid !== (i == first_bad)) $display("FAIL rnd_vv c=%0d i=%0d got=%0b exp=%0b", c, i, verdict_valid, (i == first_bad)); else n_pass++;
      end
      n_chk++; if (verdict_pass !== 1'b0 || early_reject !== 1'b1) $display("FAIL rnd_verdict c=%0d got=%0b/%0b exp=0/1", c, verdict_pass, early_reject); else n_pass++;
      exp_kc++;
      tick();
      n_chk++; if (keys_checked !== exp_kc || in_ready !== 1'b0) $display("FAIL rnd_kc c=%0d got=%h/%0b exp=%h/0", c, keys_checked, in_ready, exp_kc); else n_pass++;
    end
  endtask

  task automatic test_pass();
    string s;
    s = "the quick brown fox jumps over t";
    do_reset();
    pulse_start(24'h000111);
    for (int i = 0; i < 7; i++) send(s[i], 5'(i));
    pulse_start(24'h000249);
    for (int i = 0; i < 32; i++) begin
      send(s[i], 5'(i));
      n_chk++; if (verdict_valid !== (i == 31)) $display("FAIL pass_vv i=%0d got=%0b exp=%0b", i, verdict_valid, (i == 31)); else n_pass++;
    end
    n_chk++; if (verdict_pass !== 1'b1 || early_reject !== 1'b0) $display("FAIL pass_verdict got=%0b/%0b exp=1/0", verdict_pass, early_reject); else n_pass++;
    exp_kc++;
    tick();
    n_chk++; if (found !== 1'b1 || found_key !== 24'h000249) $display("FAIL pass_found got=%0b/%h exp=1/000249", found, found_key); else n_pass++;
    n_chk++; if (keys_checked !== exp_kc || verdict_valid !== 1'b0) $display("FAIL pass_kc got=%h/%0b exp=%h/0", keys_checked, verdict_valid, exp_kc); else n_pass++;
  endtask

  task automatic test_sticky_and_capture();
    logic [7:0] exp_rd;
    start = 1'b1; key_in = 24'h000300;
    in_valid = 1'b1; in_data = 8'h61; in_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (in_ready !== 1'b0 || found_key !== 24'h000249) $display("FAIL sticky i=%0d got=%0b/%h exp=0/000249", i, in_ready, found_key); else n_pass++;
    end
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0; in_valid = 1'b0;
    n_chk++; if (found !== 1'b1 || keys_checked !== exp_kc) $display("FAIL sticky_hold got=%0b/%h exp=1/%h", found, keys_checked, exp_kc); else n_pass++;
`ifdef RC4_PLAINTEXT_CAPTURE_EN
    exp_rd = 8'h71;
`else
    exp_rd = 8'h00;
`endif
    rd_addr = 5'd4;
    tick();
    n_chk++; if (rd_data !== exp_rd) $display("FAIL capture got=%h exp=%h", rd_data, exp_rd); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_chk++; if (found !== 1'b0 || keys_checked !== 24'h0 || found_key !== 24'h0) $display("FAIL async_rst got=%0b/%h/%h exp=0/0/0", found, keys_checked, found_key); else n_pass++;
    n_chk++; if (rd_data !== 8'h00 || in_ready !== 1'b0) $display("FAIL async_rst_misc got=%h/%0b exp=00/0", rd_data, in_ready); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_early_fail();
    test_index_mismatch();
    test_abort_restart();
    test_random_fail();
    test_pass();
    test_sticky_and_capture();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
